// File: rtl/comp_stream.sv
// comp_stream: per-word pass/ones'/negate/abs unit with a valid-ready pipeline and completed-word counter
module comp_stream #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] done_cnt
);
  logic [WIDTH-1:0] neg, res;
  logic min_neg, res_ovf;
  logic [STAGES-1:0] vld, ovf, load;
  logic [STAGES-1:0][WIDTH-1:0] data;
  logic [STAGES:0] src_vld, src_ovf;
  logic [STAGES:0][WIDTH-1:0] src_data;
  assign neg     = ~in_data + WIDTH'(1);
  assign min_neg = in_data == {1'b1, {(WIDTH-1){1'b0}}};
  always_comb begin
    res     = in_mode == 2'b00 ? in_data :
              in_mode == 2'b01 ? ~in_data :
              (in_mode == 2'b10 || in_data[WIDTH-1]) ? neg : in_data;
    res_ovf = in_mode[1] & min_neg;
  end
  assign src_vld  = {vld, in_valid};
  assign src_ovf  = {ovf, res_ovf};
  assign src_data = {data, res};
  // a stage can load if any stage from it to the output is empty, or the output drains
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign load[k] = out_ready | ~&vld[STAGES-1:k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= '0;
      ovf  <= '0;
      data <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld[k] <= src_vld[k];
          if (src_vld[k]) begin
            data[k] <= src_data[k];
            ovf[k]  <= src_ovf[k];
          end
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
  end
  assign in_ready  = load[0];
  assign out_valid = vld[STAGES-1];
  assign out_data  = data[STAGES-1];
  assign out_ovf   = ovf[STAGES-1];
endmodule

// File: tb/tb_comp_stream.sv
// tb_comp_stream: directed and random checks of comp_stream in two parameterisations
module tb_comp_stream;
  logic clk = 1'b0, rst = 1'b1;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;

  logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_ovf;
  logic [3:0] a_in_data = 0, a_out_data;
  logic [1:0] a_in_mode = 0;
  logic [7:0] a_done_cnt;

  logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_ovf;
  logic [7:0] b_in_data = 0, b_out_data;
  logic [1:0] b_in_mode = 0;
  logic [3:0] b_done_cnt;

  comp_stream u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ovf(a_out_ovf), .done_cnt(a_done_cnt)
  );

  comp_stream #(.WIDTH(8), .STAGES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ovf(b_out_ovf), .done_cnt(b_done_cnt)
  );

  // reference built on signed integer arithmetic
  function automatic logic [8:0] ref9(input logic [7:0] d, input logic [1:0] m);
    int s, r;
    bit o;
    s = d[7] ? int'(d) - 256 : int'(d);
    o = (m >= 2) && (s == -128);
    case (m)
      2'd0:    r = s;
      2'd1:    r = -s - 1;
      2'd2:    r = -s;
      default: r = s < 0 ? -s : s;
    endcase
    return {o, 8'(r)};
  endfunction

  // sends one word into u_a and returns the result; ends one negedge after the output handshake
  task automatic run_word(input logic [3:0] d, input logic [1:0] m,
                          output logic [3:0] r, output logic o, output bit got);
    got = 0;
    r = 'x;
    o = 'x;
    a_out_ready = 1;
    a_in_valid = 1;
    a_in_data = d;
    a_in_mode = m;
    @(negedge clk);
    a_in_valid = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (a_out_valid) begin
        r = a_out_data;
        o = a_out_ovf;
        got = 1;
      end else @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    vecs++;
    if (a_out_valid !== 0 || a_done_cnt !== 0 || a_out_data !== 0 || a_out_ovf !== 0)
      begin errs++; $display("FAIL reset_a: valid=%b cnt=%0d data=%h ovf=%b, want all 0", a_out_valid, a_done_cnt, a_out_data, a_out_ovf); end
    vecs++;
    if (b_out_valid !== 0 || b_done_cnt !== 0)
      begin errs++; $display("FAIL reset_b: valid=%b cnt=%0d, want 0 0", b_out_valid, b_done_cnt); end
    rst = 0;
    @(negedge clk);
    vecs++;
    if (a_in_ready !== 1 || b_in_ready !== 1)
      begin errs++; $display("FAIL reset_ready: a=%b b=%b, want 1 1", a_in_ready, b_in_ready); end
  endtask

  task automatic test_ones_stream();
    a_out_ready = 1;
    a_in_mode = 2'b01;
    for (int i = 0; i < 18; i++) begin
      a_in_valid = i < 16;
      a_in_data = 4'(i);
      #1;
      vecs++;
      if (a_in_ready !== 1) begin errs++; $display("FAIL ones_ready c%0d: got %b want 1", i, a_in_ready); end
      vecs++;
      if (i < 2) begin
        if (a_out_valid !== 0) begin errs++; $display("FAIL ones_latency c%0d: valid=%b want 0", i, a_out_valid); end
      end else if (a_out_valid !== 1 || a_out_data !== 4'(17 - i)) begin
        errs++; $display("FAIL ones_data c%0d: valid=%b data=%h want 1 %h", i, a_out_valid, a_out_data, 4'(17 - i));
      end
      @(negedge clk);
    end
    a_in_valid = 0;
    vecs++;
    if (a_done_cnt !== 8'd16 || a_out_valid !== 0)
      begin errs++; $display("FAIL ones_count: cnt=%0d valid=%b want 16 0", a_done_cnt, a_out_valid); end
  endtask

  task automatic test_modes();
    logic [3:0] d [7] = '{4'b0011, 4'b0000, 4'b1000, 4'b1010, 4'b0101, 4'b1000, 4'b1001};
    logic [1:0] m [7] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [3:0] er [7] = '{4'b1101, 4'b0000, 4'b1000, 4'b0110, 4'b0101, 4'b1000, 4'b1001};
    logic       eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] r;
    logic o;
    bit got;
    for (int i = 0; i < 7; i++) begin
      run_word(d[i], m[i], r, o, got);
      vecs++;
      if (!got) begin errs++; $display("FAIL mode_timeout w%0d: no output, want one", i); end
      vecs++;
      if (r !== er[i]) begin errs++; $display("FAIL mode_data w%0d: got %b want %b", i, r, er[i]); end
      vecs++;
      if (o !== eo[i]) begin errs++; $display("FAIL mode_ovf w%0d: got %b want %b", i, o, eo[i]); end
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    for (int c = 0; c < 12; c++) begin
      a_out_ready = c >= 6;
      a_in_valid = acc < 5;
      a_in_data = 4'(acc + 1);
      a_in_mode = 2'b00;
      #1;
      if (c < 6) begin
        vecs++;
        if (a_in_ready !== 1'(acc < 2)) begin errs++; $display("FAIL stall_ready c%0d: got %b want %b", c, a_in_ready, acc < 2); end
        if (c >= 2) begin
          vecs++;
          if (a_out_valid !== 1 || a_out_data !== 4'd1) begin errs++; $display("FAIL stall_hold c%0d: valid=%b data=%h want 1 1", c, a_out_valid, a_out_data); end
        end
      end else if (c < 11) begin
        vecs++;
        if (a_out_valid !== 1 || a_out_data !== 4'(c - 5)) begin errs++; $display("FAIL stall_order c%0d: valid=%b data=%h want 1 %h", c, a_out_valid, a_out_data, 4'(c - 5)); end
      end
      if (a_in_valid && a_in_ready) acc++;
      @(negedge clk);
    end
    a_in_valid = 0;
    vecs++;
    if (a_done_cnt !== 8'd28 || a_out_valid !== 0)
      begin errs++; $display("FAIL stall_count: cnt=%0d valid=%b want 28 0", a_done_cnt, a_out_valid); end
  endtask

  task automatic test_wrap_reset();
    b_out_ready = 1;
    b_in_mode = 2'b00;
    for (int i = 0; i < 25; i++) begin
      b_in_valid = i < 17;
      b_in_data = 8'(i);
      @(negedge clk);
    end
    vecs++;
    if (b_done_cnt !== 4'd1 || b_out_valid !== 0)
      begin errs++; $display("FAIL wrap_count: cnt=%0d valid=%b want 1 0", b_done_cnt, b_out_valid); end
    b_out_ready = 0;
    b_in_valid = 1;
    repeat (4) @(negedge clk);
    vecs++;
    if (b_out_valid !== 1 || b_in_ready !== 0)
      begin errs++; $display("FAIL wrap_full: valid=%b ready=%b want 1 0", b_out_valid, b_in_ready); end
    #1 rst = 1;
    #1;
    vecs++;
    if (b_out_valid !== 0 || b_done_cnt !== 0)
      begin errs++; $display("FAIL async_reset: valid=%b cnt=%0d want 0 0", b_out_valid, b_done_cnt); end
    b_in_valid = 0;
    b_out_ready = 1;
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    vecs++;
    if (b_out_valid !== 0 || b_done_cnt !== 0)
      begin errs++; $display("FAIL post_reset: valid=%b cnt=%0d want 0 0", b_out_valid, b_done_cnt); end
  endtask

  task automatic test_random();
    logic [8:0] sb [$];
    logic [8:0] exp;
    int sent = 0, recv = 0, cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      b_in_valid = sent < 1000 && $urandom_range(0, 3) != 0;
      b_in_data = 8'($urandom);
      b_in_mode = 2'($urandom);
      b_out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (b_out_valid && b_out_ready) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL rand_extra: got %h with no word pending", b_out_data);
        end else begin
          exp = sb.pop_front();
          if ({b_out_ovf, b_out_data} !== exp) begin errs++; $display("FAIL rand_word %0d: got ovf=%b data=%h want ovf=%b data=%h", recv, b_out_ovf, b_out_data, exp[8], exp[7:0]); end
        end
        recv++;
      end
      if (b_in_valid && b_in_ready) begin
        sb.push_back(ref9(b_in_data, b_in_mode));
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    vecs++;
    if (recv != 1000 || sb.size() != 0)
      begin errs++; $display("FAIL rand_total: got %0d words (%0d left) want 1000 (0 left)", recv, sb.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ones_stream();
    test_modes();
    test_stall();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
